cla_pipe_arbiter: RTL and testbench

- Shares one pipelined 32-bit carry-lookahead adder between two requesters.
- Accepts operand pairs over valid/ready handshakes and arbitrates round-robin, issuing at most one operation per clock.
- Carries a requester tag down a shadow pipeline matched to the adder latency, then routes each sum/carry back to its owner.
- Sits between requester logic and the adder instance; the adder itself is external.

---
 rtl/cla_pipe_arbiter.sv | 176 +++++++++++++++++
 tb/tb_cla_pipe_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cla_pipe_arbiter: round-robin share of one pipelined CLA between two     |
// | requesters, with a tag shadow pipe. Option macro: CLA_PIPE_ARB_PERF_EN   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cla_pipe_arbiter #(
   parameter int WIDTH        = 32,
   parameter int LATENCY      = 5,
   parameter int MAX_INFLIGHT = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic             res0_valid,
   output logic             res1_valid,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_cout,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout,
`ifdef CLA_PIPE_ARB_PERF_EN
   output logic [31:0]      perf_grant0,
   output logic [31:0]      perf_grant1,
   output logic [31:0]      perf_stall,
   input  logic             perf_clr,
`endif
   output logic             busy
);

   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

   logic               ptr_q, ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   add_a_q, add_a_d, add_b_q, add_b_d;
   logic               add_cin_q, add_cin_d;
   logic [LATENCY-1:0] tag_vld_q, tag_vld_d, tag_id_q, tag_id_d;
   logic               res0_valid_q, res0_valid_d, res1_valid_q, res1_valid_d;
   logic [WIDTH-1:0]   res_sum_q, res_sum_d;
   logic               res_cout_q, res_cout_d;
   logic               busy_q, busy_d;
   logic               slot_ok, grant0, grant1, grant, done;

   always_comb begin
      slot_ok = (count_q < CNT_W'(MAX_INFLIGHT));
      grant0  = slot_ok && req0_valid && (!req1_valid || !ptr_q);
      grant1  = slot_ok && req1_valid && (!req0_valid || ptr_q);
      grant   = grant0 || grant1;
      done    = tag_vld_q[LATENCY-1];

      // Pointer always names the requester that did not just win.
      ptr_d = grant ? grant0 : ptr_q;

      add_a_d   = add_a_q;
      add_b_d   = add_b_q;
      add_cin_d = add_cin_q;
      if (grant0) begin
         add_a_d   = req0_a;
         add_b_d   = req0_b;
         add_cin_d = req0_cin;
      end else if (grant1) begin
         add_a_d   = req1_a;
         add_b_d   = req1_b;
         add_cin_d = req1_cin;
      end

      tag_vld_d    = '0;
      tag_id_d     = '0;
      tag_vld_d[0] = grant;
      tag_id_d[0]  = grant1;
      for (int i = 1; i < LATENCY; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_id_d[i]  = tag_id_q[i-1];
      end

      case ({grant, done})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      busy_d = (count_d != '0);

      res0_valid_d = done && !tag_id_q[LATENCY-1];
      res1_valid_d = done &&  tag_id_q[LATENCY-1];
      res_sum_d    = done ? add_sum  : res_sum_q;
      res_cout_d   = done ? add_cout : res_cout_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q        <= 1'b0;
         count_q      <= '0;
         add_a_q      <= '0;
         add_b_q      <= '0;
         add_cin_q    <= 1'b0;
         tag_vld_q    <= '0;
         tag_id_q     <= '0;
         res0_valid_q <= 1'b0;
         res1_valid_q <= 1'b0;
         res_sum_q    <= '0;
         res_cout_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         ptr_q        <= ptr_d;
         count_q      <= count_d;
         add_a_q      <= add_a_d;
         add_b_q      <= add_b_d;
         add_cin_q    <= add_cin_d;
         tag_vld_q    <= tag_vld_d;
         tag_id_q     <= tag_id_d;
         res0_valid_q <= res0_valid_d;
         res1_valid_q <= res1_valid_d;
         res_sum_q    <= res_sum_d;
         res_cout_q   <= res_cout_d;
         busy_q       <= busy_d;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign add_a      = add_a_q;
   assign add_b      = add_b_q;
   assign add_cin    = add_cin_q;
   assign res0_valid = res0_valid_q;
   assign res1_valid = res1_valid_q;
   assign res_sum    = res_sum_q;
   assign res_cout   = res_cout_q;
   assign busy       = busy_q;

`ifdef CLA_PIPE_ARB_PERF_EN
   logic [31:0] perf_grant0_q, perf_grant0_d;
   logic [31:0] perf_grant1_q, perf_grant1_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   // Clear wins over a same-cycle increment.
   always_comb begin
      perf_grant0_d = perf_grant0_q + {31'd0, grant0};
      perf_grant1_d = perf_grant1_q + {31'd0, grant1};
      perf_stall_d  = perf_stall_q + {31'd0, (req0_valid || req1_valid) && !grant};
      if (perf_clr) begin
         perf_grant0_d = '0;
         perf_grant1_d = '0;
         perf_stall_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_grant0_q <= '0;
         perf_grant1_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         perf_grant0_q <= perf_grant0_d;
         perf_grant1_q <= perf_grant1_d;
         perf_stall_q  <= perf_stall_d;
      end
   end

   assign perf_grant0 = perf_grant0_q;
   assign perf_grant1 = perf_grant1_q;
   assign perf_stall  = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cla_pipe_arbiter: directed bench for cla_pipe_arbiter (MAX_INFLIGHT=2)|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cla_pipe_arbiter;
   localparam int WIDTH        = 32;
   localparam int LATENCY      = 5;
   localparam int MAX_INFLIGHT = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req0_ready, req0_cin;
   logic [WIDTH-1:0] req0_a, req0_b;
   logic             req1_valid, req1_ready, req1_cin;
   logic [WIDTH-1:0] req1_a, req1_b;
   logic             res0_valid, res1_valid, res_cout, add_cin, add_cout, busy;
   logic [WIDTH-1:0] res_sum, add_a, add_b, add_sum;
`ifdef CLA_PIPE_ARB_PERF_EN
   logic [31:0]      perf_grant0, perf_grant1, perf_stall;
   logic             perf_clr = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cla_pipe_arbiter #(.WIDTH(WIDTH), .LATENCY(LATENCY), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
      .res0_valid(res0_valid), .res1_valid(res1_valid), .res_sum(res_sum), .res_cout(res_cout),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
`ifdef CLA_PIPE_ARB_PERF_EN
      .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall), .perf_clr(perf_clr),
`endif
      .busy(busy)
   );

   // External adder: the issue register inside the arbiter is the first of
   // the LATENCY clocks, so the adder itself contributes LATENCY-1 stages.
   logic [WIDTH:0] mdl_pipe [LATENCY-1];
   always @(posedge clk) begin
      mdl_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
      for (int i = 1; i < LATENCY - 1; i++) mdl_pipe[i] <= mdl_pipe[i-1];
   end
   assign add_sum  = mdl_pipe[LATENCY-2][WIDTH-1:0];
   assign add_cout = mdl_pipe[LATENCY-2][WIDTH];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   function automatic logic [WIDTH:0] sum_of(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic c);
      return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH:0] q0[$];
      logic [WIDTH:0] q1[$];
      logic [WIDTH:0] e;
      logic           g0_prev, g1_prev;
      logic           exp_turn;
      int             n0, n1, ngr;

      rst_n = 1'b1;
      req0_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0;
      req1_valid = 0; req1_a = '0; req1_b = '0; req1_cin = 0;
      #2 rst_n = 1'b0;

      // Reset state
      cyc(); #1;
      chk("rst_res0_valid", res0_valid, 0);
      chk("rst_res1_valid", res1_valid, 0);
      chk("rst_res_sum", res_sum, 0);
      chk("rst_res_cout", res_cout, 0);
      chk("rst_add_a", add_a, 0);
      chk("rst_add_b", add_b, 0);
      chk("rst_add_cin", add_cin, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready0", req0_ready, 0);
      cyc(); rst_n = 1'b1;

      // Single op on requester 0: 1 + 0xFFFFFFFF
      for (int k = 0; k <= 7; k++) begin
         cyc();
         req0_valid = (k == 0);
         req0_a = 32'h0000_0001; req0_b = 32'hFFFF_FFFF; req0_cin = 0;
         #1;
         chk("single_ready0", req0_ready, k == 0);
         chk("single_res0_valid", res0_valid, k == 6);
         chk("single_res1_valid", res1_valid, 0);
         chk("single_busy", busy, (k >= 1 && k <= 5));
         if (k == 1) begin
            chk("single_add_a", add_a, 32'h0000_0001);
            chk("single_add_b", add_b, 32'hFFFF_FFFF);
            chk("single_add_cin", add_cin, 0);
         end
         if (k == 6 || k == 7) begin
            chk("single_sum", res_sum, 32'h0000_0000);
            chk("single_cout", res_cout, 1);
         end
      end

      // Carry-in on requester 1: 0x7FFFFFFF + 0 + 1
      for (int k = 0; k <= 6; k++) begin
         cyc();
         req1_valid = (k == 0);
         req1_a = 32'h7FFF_FFFF; req1_b = 32'h0; req1_cin = 1;
         #1;
         chk("cin_ready1", req1_ready, k == 0);
         chk("cin_res1_valid", res1_valid, k == 6);
         chk("cin_res0_valid", res0_valid, 0);
         if (k == 6) begin
            chk("cin_sum", res_sum, 32'h8000_0000);
            chk("cin_cout", res_cout, 0);
         end
      end
      req1_cin = 0;

      // Contention: both valid; grants must alternate and results route home
      n0 = 0; n1 = 0; ngr = 0; g0_prev = 0; g1_prev = 0; exp_turn = 0;
      for (int k = 0; k < 22; k++) begin
         cyc();
         if (g0_prev) n0++;
         if (g1_prev) n1++;
         req0_a = 32'h1000_0000 + 32'(n0); req0_b = 32'h0000_00FF; req0_cin = n0[0];
         req1_a = 32'hFFFF_FFF0;           req1_b = 32'(n1) + 32'd16; req1_cin = 1;
         req0_valid = (k < 14);
         req1_valid = (k < 14);
         #1;
         chk("cont_one_ready", req0_ready & req1_ready, 0);
         g0_prev = req0_ready;
         g1_prev = req1_ready;
         if (req0_ready || req1_ready) begin
            ngr++;
            chk("cont_turn", req1_ready, exp_turn);
            exp_turn = ~exp_turn;
            if (req0_ready) q0.push_back(sum_of(req0_a, req0_b, req0_cin));
            else            q1.push_back(sum_of(req1_a, req1_b, req1_cin));
         end
         if (res0_valid) begin
            chk("cont_res0_pending", q0.size() != 0, 1);
            if (q0.size() != 0) begin
               e = q0.pop_front();
               chk("cont_res0_sum", {res_cout, res_sum}, e);
            end
         end
         if (res1_valid) begin
            chk("cont_res1_pending", q1.size() != 0, 1);
            if (q1.size() != 0) begin
               e = q1.pop_front();
               chk("cont_res1_sum", {res_cout, res_sum}, e);
            end
         end
      end
      chk("cont_grants", ngr, 6);
      chk("cont_q0_empty", q0.size(), 0);
      chk("cont_q1_empty", q1.size(), 0);
      req1_cin = 0;

      // Saturation: two slots, then one issue per completion
      for (int k = 0; k < 22; k++) begin
         cyc();
         req0_valid = (k < 14);
         req0_a = 32'h5; req0_b = 32'h6; req0_cin = 0;
         #1;
         chk("sat_ready0", req0_ready, (k == 0 || k == 1 || k == 6 || k == 7 || k == 12 || k == 13));
         chk("sat_res0_valid", res0_valid, (k == 6 || k == 7 || k == 12 || k == 13 || k == 18 || k == 19));
         chk("sat_res1_valid", res1_valid, 0);
         chk("sat_busy", busy, (k >= 1 && k <= 18));
         if (res0_valid) chk("sat_sum", {res_cout, res_sum}, 33'h0_0000_000B);
      end

      // Requester 0 valid every other cycle
      for (int k = 0; k <= 12; k++) begin
         cyc();
         req0_valid = (k == 0 || k == 2);
         if (k == 0) begin req0_a = 32'h3; req0_b = 32'h4; req0_cin = 0; end
         else begin req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF; req0_cin = 1; end
         #1;
         chk("gap_ready0", req0_ready, (k == 0 || k == 2));
         chk("gap_res0_valid", res0_valid, (k == 6 || k == 8));
         chk("gap_res1_valid", res1_valid, 0);
         if (k == 6 || k == 7) chk("gap_sum_a", {res_cout, res_sum}, 33'h0_0000_0007);
         if (k == 8)           chk("gap_sum_b", {res_cout, res_sum}, 33'h1_FFFF_FFFF);
      end

      // Reset with two ops in flight; pointer left at requester 1
      cyc(); req0_valid = 0; req1_valid = 1; req1_a = 32'h1; req1_b = 32'h1; #1;
      chk("rmid_ready1", req1_ready, 1);
      cyc(); req1_valid = 0; req0_valid = 1; req0_a = 32'h2; req0_b = 32'h2; req0_cin = 0; #1;
      chk("rmid_ready0", req0_ready, 1);
      cyc(); req0_valid = 0; #1;
      chk("rmid_busy_before", busy, 1);
      rst_n = 1'b0; #1;
      chk("rmid_busy_rst", busy, 0);
      chk("rmid_add_a_rst", add_a, 0);
      chk("rmid_sum_rst", res_sum, 0);
      cyc(); rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cyc(); #1;
         chk("rmid_no_res0", res0_valid, 0);
         chk("rmid_no_res1", res1_valid, 0);
         chk("rmid_busy_after", busy, 0);
      end
      cyc();
      req0_valid = 1; req0_a = 32'h10; req0_b = 32'h20; req0_cin = 0;
      req1_valid = 1; req1_a = 32'h40; req1_b = 32'h80; req1_cin = 0;
      #1;
      chk("rmid_ptr_ready0", req0_ready, 1);
      chk("rmid_ptr_ready1", req1_ready, 0);
      for (int k = 1; k <= 6; k++) begin
         cyc(); req0_valid = 0; req1_valid = 0; #1;
         chk("rmid_res0_valid", res0_valid, k == 6);
         chk("rmid_res1_valid", res1_valid, 0);
         if (k == 6) chk("rmid_sum", {res_cout, res_sum}, 33'h0_0000_0030);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
